bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock. It sits directly upstream of the seven-segment decoder bank. It turns a binary count, such as the track number or elapsed seconds, into packed BCD digits, one nibble per display driver. It can optionally replace leading zeros with an out-of-range nibble that the downstream decoder renders as a blank digit.

## Interface
- WIDTH, default 10: binary input width; number of shift iterations.
- DIGITS, default 4: BCD digits produced. Must satisfy 10^DIGITS > 2^WIDTH - 1. This is not checked in RTL.
- BLANK_LZ, default 1: 1 = replace leading zero digits with 4'hF; 0 = plain BCD.
- Clocking and reset (already decided): one clock; reset is synchronous and active-high.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  conversion request; sampled only in IDLE.
- bin  in  WIDTH  binary value; captured on the edge that accepts start.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse; bcd updated on the same edge.
- bcd  out  4*DIGITS  packed result; digit 0 (units) in bits [3:0], digit i in [4i+3:4i].

## Operation
- States: IDLE, CONV.
- IDLE:
  - On start=1: load the shift register with bin, clear the scratch BCD, set the iteration counter to WIDTH, and go to CONV.
- CONV, each cycle:
  - Every scratch digit >= 5 gets +3 (4-bit add, no carry out).
  - Then {scratch, shift} shifts left by 1, taking the shift-register MSB into scratch bit 0.
  - The counter decrements.
- Last iteration (counter = 1):
  - The post-shift scratch value is written to bcd, with the blanking rule applied.
  - done goes to 1 and the state returns to IDLE.
- Blanking, when BLANK_LZ=1:
  - Scan from the most significant digit down.
  - Each digit equal to 0 is output as 4'hF until the first nonzero digit.
  - Digit 0 is never blanked, so value 0 is output as F…F0.
- start while in CONV is ignored. It is not queued, and bin changes are not sampled.
- bcd holds its last result between conversions. It is not cleared at start.
- Digit values written to bcd are always 0–9, or F when blanked.

## Timing
- Reset values: state=IDLE, busy=0, done=0, bcd=0 for all digits (no blanking applied at reset), counter=0.
- rst=1 mid-conversion aborts it:
  - The reset values above are applied on that edge.
  - No done pulse is produced and the partial result is discarded.
- Start accepted at edge k:
  - busy=1 from after edge k through edge k+WIDTH.
  - Iterations happen at edges k+1 … k+WIDTH.
  - At edge k+WIDTH, bcd updates, done=1 and busy=0.
  - done is visible in the cycle after edge k+WIDTH and clears at edge k+WIDTH+1.
- Latency is WIDTH cycles from the accepting edge to done.
- Back-to-back: start=1 during the done cycle is accepted, because the state is already IDLE. Sustained throughput is one result per WIDTH+1 cycles.
- busy and done are never high in the same cycle.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package bin2bcd_pkg:
  - State encoding: IDLE=1'b0, CONV=1'b1.
  - Constant BCD_BLANK = 4'hF, matching the decoder's blank code.
  - Helper function for the counter width, $clog2(WIDTH+1).
- Sub-module bcd_add3: combinational 4-bit in, 4-bit out; output is in+3 if in>=5, else in. Instantiated DIGITS times by generate.
- Top level holds the FSM, counter, shift register, scratch register, and blanking logic on the output write.

## Test plan
- Reset, then 0 with BLANK_LZ=1: start with bin=0 → after 10 cycles done=1, bcd=16'hFFF0.
- Full scale, BLANK_LZ=1: bin=1023 → bcd=16'h1023. done rises exactly 10 cycles after the accepting edge, and busy is high for those 10 cycles.
- Leading-zero blanking: bin=255 → 16'hF255 with BLANK_LZ=1, and 16'h0255 with BLANK_LZ=0.
- Start during CONV: bin=37 accepted, then start with bin=999 raised 3 cycles later → single done with bcd=16'hFF37. No second conversion follows.
- Reset mid-operation: rst=1 at iteration 5 of bin=512 → busy=0 and bcd=0 on the next cycle, no done pulse. A fresh start with bin=512 afterwards → bcd=16'hF512.
- Back-to-back: start held high continuously with bin stepping 9, 10, 11 → done every 11 cycles, results FFF9, FF10, FF11 in order.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, the decoder's blank-digit code and a counter-width helper.
package bin2bcd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  // Nibble value the seven-segment decoder renders as an unlit digit
  localparam logic [3:0] BCD_BLANK = 4'hF;

  // Bits needed to hold an iteration count running from width down to 0
  function automatic int cntWidth(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a client and the binary-to-BCD converter.
// The client raises start with bin; the converter answers with busy, a done
// pulse and the packed BCD result.
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
);

  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;

  modport master (
    output start,
    output bin,
    input  busy,
    input  done,
    input  bcd
  );

  modport slave (
    input  start,
    input  bin,
    output busy,
    output done,
    output bcd
  );

endinterface

// File: rtl/bcd_add3.sv
// Single-digit correction step of the double-dabble algorithm: a digit that
// would overflow past 9 after the next doubling is pre-adjusted by +3.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Add 3 to digits of 5 or more; the 4-bit sum never needs a carry out
  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
// clock. Feeds the seven-segment decoder bank; leading zero digits can be
// replaced by the decoder's blank code so unused digits stay dark.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int DIGITS   = 4,
  parameter int BLANK_LZ = 1
) (
  input logic          clk,
  input logic          rst,
  bin2bcd_seq_if.slave bus
);

  localparam int CW = cntWidth(WIDTH);
  localparam int BW = 4 * DIGITS;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t           state;
  state_t           stateNext;
  logic             load;
  logic             step;
  logic             last;

  logic [WIDTH-1:0] shiftReg;
  logic [BW-1:0]    scratch;
  logic [CW-1:0]    count;
  logic [BW-1:0]    bcdReg;
  logic             doneReg;

  logic [BW-1:0]    adjusted;
  logic [BW-1:0]    shifted;
  logic [BW-1:0]    blanked;
  logic [BW-1:0]    result;
  logic             leading;

  // One +3 corrector per scratch digit, all working in parallel each cycle
  for (genvar d = 0; d < DIGITS; d++) begin : gAdd
    bcd_add3 uAdd (
      .din  (scratch[4*d +: 4]),
      .dout (adjusted[4*d +: 4])
    );
  end

  // State register; reset drops any conversion in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and datapath strobes: accept start only when idle, run one
  // iteration per cycle in CONV and leave after the iteration with count 1
  always_comb begin
    stateNext = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          stateNext = CONV;
        end
      end
      CONV: begin
        step = 1'b1;
        if (count == CNT_ONE) begin
          last      = 1'b1;
          stateNext = IDLE;
        end
      end
    endcase
  end

  // Adjusted scratch shifted left with the next binary bit entering at the
  // bottom; the top bit falls off, which the digit-count sizing makes safe
  always_comb begin
    shifted = (adjusted << 1) | BW'(shiftReg[WIDTH-1]);
  end

  // Blank zero digits from the top down until the first nonzero one;
  // the units digit always shows so a zero result still reads as 0
  always_comb begin
    blanked = shifted;
    leading = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (leading && (shifted[4*i +: 4] == 4'd0)) begin
        blanked[4*i +: 4] = BCD_BLANK;
      end else begin
        leading = 1'b0;
      end
    end
  end

  // Choose between blanked and plain BCD for the output write
  always_comb begin
    result = (BLANK_LZ != 0) ? blanked : shifted;
  end

  // Shift/scratch/counter iteration plus the registered result and done pulse;
  // bcd keeps its previous value until a conversion completes
  always_ff @(posedge clk) begin
    if (rst) begin
      shiftReg <= '0;
      scratch  <= '0;
      count    <= '0;
      bcdReg   <= '0;
      doneReg  <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      if (load) begin
        shiftReg <= bus.bin;
        scratch  <= '0;
        count    <= CNT_LOAD;
      end else if (step) begin
        shiftReg <= shiftReg << 1;
        scratch  <= shifted;
        count    <= count - CNT_ONE;
        if (last) begin
          bcdReg  <= result;
          doneReg <= 1'b1;
        end
      end
    end
  end

  assign bus.busy = (state == CONV);
  assign bus.done = doneReg;
  assign bus.bcd  = bcdReg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq. Two converters run side by side on the
// same stimulus, one with leading-zero blanking and one without.
module tb_bin2bcd_seq;

  localparam int WIDTH  = 10;
  localparam int DIGITS = 4;

  typedef struct {
    string       name;
    int unsigned value;
    logic [15:0] expBlank;
    logic [15:0] expPlain;
  } vec_t;

  logic clk;
  logic rst;

  bin2bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) busB ();
  bin2bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) busP ();

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS), .BLANK_LZ(1)) dutBlank (
    .clk (clk),
    .rst (rst),
    .bus (busB)
  );

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS), .BLANK_LZ(0)) dutPlain (
    .clk (clk),
    .rst (rst),
    .bus (busP)
  );

  int checks   = 0;
  int failures = 0;
  int overlapCount = 0;

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watch for busy and done ever being high together on either converter
  always @(negedge clk) begin
    if ((busB.busy && busB.done) || (busP.busy && busP.done)) begin
      overlapCount++;
    end
  end

  // Decimal digits by plain division; digits above the value's decimal
  // length become F when blanking is enabled (units digit always kept)
  function automatic logic [15:0] refBcd(input int unsigned value, input bit blank);
    logic [15:0] r;
    int unsigned v;
    int unsigned lim;
    int sig;
    v = value;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    sig = 1;
    lim = 10;
    while (sig < 4 && value >= lim) begin
      sig++;
      lim = lim * 10;
    end
    if (blank) begin
      for (int i = sig; i < 4; i++) begin
        r[4*i +: 4] = 4'hF;
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic driveStart(input logic s, input int unsigned value);
    busB.start = s;
    busP.start = s;
    busB.bin   = 10'(value);
    busP.bin   = 10'(value);
  endtask

  // Present start for one edge; returns at the negedge after the accepting edge
  task automatic applyStimulus(input int unsigned value);
    @(negedge clk);
    driveStart(1'b1, value);
    @(posedge clk);
    @(negedge clk);
    busB.start = 1'b0;
    busP.start = 1'b0;
  endtask

  task automatic runConversion(input string name, input int unsigned value,
                               input logic [15:0] expB, input logic [15:0] expP);
    int doneB;
    int doneP;
    int busyCnt;
    logic [15:0] gotB;
    logic [15:0] gotP;
    doneB   = -1;
    doneP   = -1;
    busyCnt = 0;
    gotB    = '0;
    gotP    = '0;
    applyStimulus(value);
    if (busB.busy) busyCnt++;
    for (int j = 1; j <= 20 && doneB < 0; j++) begin
      @(negedge clk);
      if (busB.busy) busyCnt++;
      if (busB.done && doneB < 0) begin
        doneB = j;
        gotB  = busB.bcd;
      end
      if (busP.done && doneP < 0) begin
        doneP = j;
        gotP  = busP.bcd;
      end
    end
    checkOutput({name, " latencyBlank"}, doneB, WIDTH);
    checkOutput({name, " latencyPlain"}, doneP, WIDTH);
    checkOutput({name, " busyCycles"}, busyCnt, WIDTH);
    checkOutput({name, " bcdBlank"}, {16'h0, gotB}, {16'h0, expB});
    checkOutput({name, " bcdPlain"}, {16'h0, gotP}, {16'h0, expP});
    @(negedge clk);
    checkOutput({name, " doneCleared"}, {31'h0, busB.done}, 32'h0);
  endtask

  vec_t vecs[$];

  initial begin
    int doneCnt;
    int accepts;
    logic prevBusy;
    logic [15:0] gotB;
    logic [15:0] gotP;
    int unsigned vals[3];
    logic [15:0] res[3];
    int doneAt[3];
    int unsigned rv;

    vecs.push_back('{"zero",     0,    16'hFFF0, 16'h0000});
    vecs.push_back('{"fullScale",1023, 16'h1023, 16'h1023});
    vecs.push_back('{"lz255",    255,  16'hF255, 16'h0255});
    vecs.push_back('{"single7",  7,    16'hFFF7, 16'h0007});
    vecs.push_back('{"inner100", 100,  16'hF100, 16'h0100});
    vecs.push_back('{"thou1000", 1000, 16'h1000, 16'h1000});
    vecs.push_back('{"two99",    99,   16'hFF99, 16'h0099});

    rst = 1'b1;
    driveStart(1'b0, 0);
    repeat (3) @(negedge clk);
    checkOutput("resetBusy", {31'h0, busB.busy}, 32'h0);
    checkOutput("resetDone", {31'h0, busB.done}, 32'h0);
    checkOutput("resetBcdBlank", {16'h0, busB.bcd}, 32'h0);
    checkOutput("resetBcdPlain", {16'h0, busP.bcd}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      runConversion(vecs[i].name, vecs[i].value, vecs[i].expBlank, vecs[i].expPlain);
    end

    // Start raised mid-conversion must be ignored entirely
    applyStimulus(37);
    doneCnt = 0;
    gotB = '0;
    gotP = '0;
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      if (j == 2) driveStart(1'b1, 999);
      if (j == 5) driveStart(1'b0, 999);
      if (busB.done) begin
        doneCnt++;
        if (doneCnt == 1) begin
          gotB = busB.bcd;
          gotP = busP.bcd;
        end
      end
    end
    checkOutput("ignoreStart doneCount", doneCnt, 1);
    checkOutput("ignoreStart bcdBlank", {16'h0, gotB}, 32'h0000FF37);
    checkOutput("ignoreStart bcdPlain", {16'h0, gotP}, 32'h00000037);
    checkOutput("ignoreStart idleAfter", {31'h0, busB.busy}, 32'h0);

    // Reset on the fifth iteration edge aborts without a done pulse
    applyStimulus(512);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midReset busy", {31'h0, busB.busy}, 32'h0);
    checkOutput("midReset bcd", {16'h0, busB.bcd}, 32'h0);
    checkOutput("midReset done", {31'h0, busB.done}, 32'h0);
    rst = 1'b0;
    doneCnt = 0;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      if (busB.done || busP.done) doneCnt++;
    end
    checkOutput("midReset noDone", doneCnt, 0);
    runConversion("afterReset", 512, 16'hF512, 16'h0512);

    // Start held high: each done cycle doubles as the next accept
    vals[0] = 9;
    vals[1] = 10;
    vals[2] = 11;
    for (int i = 0; i < 3; i++) begin
      res[i]    = '0;
      doneAt[i] = -1;
    end
    doneCnt  = 0;
    accepts  = 0;
    prevBusy = 1'b0;
    @(negedge clk);
    driveStart(1'b1, vals[0]);
    for (int cyc = 1; cyc <= 60 && doneCnt < 3; cyc++) begin
      @(negedge clk);
      if (busB.busy && !prevBusy) begin
        accepts++;
        if (accepts < 3) driveStart(1'b1, vals[accepts]);
        else driveStart(1'b0, 0);
      end
      prevBusy = busB.busy;
      if (busB.done) begin
        res[doneCnt]    = busB.bcd;
        doneAt[doneCnt] = cyc;
        doneCnt++;
      end
    end
    driveStart(1'b0, 0);
    checkOutput("b2b doneCount", doneCnt, 3);
    checkOutput("b2b result0", {16'h0, res[0]}, 32'h0000FFF9);
    checkOutput("b2b result1", {16'h0, res[1]}, 32'h0000FF10);
    checkOutput("b2b result2", {16'h0, res[2]}, 32'h0000FF11);
    checkOutput("b2b spacing1", doneAt[1] - doneAt[0], WIDTH + 1);
    checkOutput("b2b spacing2", doneAt[2] - doneAt[1], WIDTH + 1);
    repeat (3) @(negedge clk);

    // Random values against the arithmetic reference model
    for (int n = 0; n < 12; n++) begin
      rv = $urandom_range(1023, 0);
      runConversion($sformatf("rand%0d_%0d", n, rv), rv, refBcd(rv, 1'b1), refBcd(rv, 1'b0));
    end

    checkOutput("busyDoneOverlap", overlapCount, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
